sys_cmd_master: RTL and testbench
=================================

// Module: sys_cmd_master
// PURPOSE
//   Host-side command initiator for the UART register-file/ALU command protocol.
//   Takes one command per request handshake and serialises it into the protocol frame, one
//   byte at a time, into the UART TX parallel interface. It then collects the response bytes
//   from the UART RX parallel interface and returns them as a single response.
//   Sits between host/test logic and the UART_TX/UART_RX pair that faces the system controller.
// PARAMETERS
//   DATA_WIDTH   8      UART byte width; frame bytes and RX/TX data are this wide
//   TIMEOUT      4096   max CLK cycles waited for each response byte (>=2)
// PORTS
//   CLK            in   1   system clock
//   RST            in   1   async active-low reset
//   CMD_Valid      in   1   command request
//   CMD_Ready      out  1   high only in IDLE; command accepted when CMD_Valid & CMD_Ready
//   CMD_Type       in   2   00 RF_WR, 01 RF_RD, 10 ALU_OP, 11 ALU_NOP
//   CMD_Addr       in   4   register-file address (RF_WR/RF_RD)
//   CMD_Data       in   8   write data (RF_WR)
//   CMD_OpA        in   8   ALU operand A (ALU_OP)
//   CMD_OpB        in   8   ALU operand B (ALU_OP)
//   CMD_Func       in   4   ALU function (ALU_OP/ALU_NOP)
//   TX_P_Data      out  8   frame byte to UART TX
//   TX_Data_Valid  out  1   one-cycle byte strobe to UART TX
//   TX_Busy        in   1   UART TX busy
//   RX_P_Data      in   8   byte from UART RX
//   RX_Data_Valid  in   1   one-cycle received-byte strobe
//   RSP_Data       out  16  response payload
//   RSP_Valid      out  1   one-cycle response strobe
//   RSP_Timeout    out  1   qualifies RSP_Valid: response incomplete
// BEHAVIOUR
//   All outputs registered. Reset: CMD_Ready=0 (goes to 1 the cycle after reset release),
//   TX_P_Data=8'hFF, TX_Data_Valid=0, RSP_Data=0, RSP_Valid=0, RSP_Timeout=0, FSM=IDLE.
//   Reset mid-operation aborts the frame immediately; no response is produced.
//   Frames (fields latched at accept; address/func zero-extended to 8 bits):
//     RF_WR  : AA, addr, data       -> 0 response bytes
//     RF_RD  : BB, addr             -> 1 response byte
//     ALU_OP : CC, A, B, func       -> 2 response bytes, LSB first
//     ALU_NOP: DD, func             -> 2 response bytes, LSB first
//   FSM states:
//     IDLE : CMD_Ready=1. On accept, latch fields, byte index=0, and go to SEND.
//     SEND : issue the byte at the current index when TX_Busy=0 and tx_pending=0.
//            Issuing drives TX_Data_Valid=1 for exactly one cycle and sets TX_P_Data to the byte.
//            TX_P_Data returns to FF afterwards. After the last byte: go to RSP, or to DONE
//            if 0 response bytes are expected.
//     RSP  : capture each RX_Data_Valid byte into the next response slot.
//            The timeout counter loads TIMEOUT on entry and on each byte, and decrements otherwise.
//            All expected bytes received -> DONE.
//            Counter reaches 0 -> DONE with timeout flag.
//     DONE : RSP_Valid=1 for one cycle, then IDLE (next CMD_Ready in the following cycle).
//   tx_pending: set when a byte is issued; cleared when TX_Busy is seen 1 and then 0.
//     This guarantees no byte is issued before UART TX has registered the previous one.
//   RSP_Data: RF_RD -> {8'h00, b0}; ALU -> {b1, b0}; RF_WR -> 16'h0000.
//     On timeout, slots not yet received read 0 and RSP_Timeout=1.
//   RX bytes arriving in IDLE/SEND/DONE, or after all expected bytes: discarded.
//   An RX byte in the same cycle the counter would hit 0: the byte wins and the counter reloads.
//   Unknown FSM encodings recover to IDLE with reset output values.
// TESTING
//   RF_WR addr=5 data=3C -> TX bytes AA,05,3C, each issued only after TX_Busy 1->0; RSP_Valid, data 0000, Timeout=0
//   RF_RD addr=2; RX returns 7E -> TX BB,02; RSP_Data=007E, Timeout=0
//   ALU_OP A=0A B=14 func=0; RX returns C8 then 00 -> TX CC,0A,14,00; RSP_Data=00C8
//   ALU_NOP func=2; RX returns only 34 -> after TIMEOUT idle cycles RSP_Valid, RSP_Data=0034, Timeout=1
//   TX_Busy held high 100 cycles mid-frame -> no TX_Data_Valid until busy falls; spurious RX byte in SEND ignored
//   RST low during ALU_OP byte 3 -> outputs at reset values, no RSP_Valid; next command sends a clean frame

Source files
------------

// File: rtl/sys_cmd_master.sv
// Host-side command initiator: serialises one command into a UART frame, then
// gathers the response bytes (with a per-byte timeout) into one 16-bit response.
`timescale 1ns/1ps
module sys_cmd_master #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CMD_Valid,
    output logic                      CMD_Ready,
    input  logic [1:0]                CMD_Type,
    input  logic [3:0]                CMD_Addr,
    input  logic [7:0]                CMD_Data,
    input  logic [7:0]                CMD_OpA,
    input  logic [7:0]                CMD_OpB,
    input  logic [3:0]                CMD_Func,
    output logic [DATA_WIDTH-1:0]     TX_P_Data,
    output logic                      TX_Data_Valid,
    input  logic                      TX_Busy,
    input  logic [DATA_WIDTH-1:0]     RX_P_Data,
    input  logic                      RX_Data_Valid,
    output logic [2*DATA_WIDTH-1:0]   RSP_Data,
    output logic                      RSP_Valid,
    output logic                      RSP_Timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_RSP  = 3'd2,
        ST_DONE = 3'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   frame_reg [4];
    logic [DATA_WIDTH-1:0]   frame_next [4];
    logic [1:0]              idx_reg, idx_next;
    logic [1:0]              last_idx_reg, last_idx_next;
    logic [1:0]              rsp_need_reg, rsp_need_next;
    logic [1:0]              rsp_cnt_reg, rsp_cnt_next;
    logic [DATA_WIDTH-1:0]   rsp_b_reg [2];
    logic [DATA_WIDTH-1:0]   rsp_b_next [2];
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    tx_pending_reg, tx_pending_next;
    logic                    busy_seen_reg, busy_seen_next;
    logic                    cmd_ready_reg, cmd_ready_next;
    logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic                    tx_valid_reg, tx_valid_next;
    logic [2*DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= ST_IDLE;
            frame_reg       <= '{default: '0};
            idx_reg         <= '0;
            last_idx_reg    <= '0;
            rsp_need_reg    <= '0;
            rsp_cnt_reg     <= '0;
            rsp_b_reg       <= '{default: '0};
            timer_reg       <= '0;
            tx_pending_reg  <= 1'b0;
            busy_seen_reg   <= 1'b0;
            cmd_ready_reg   <= 1'b0;
            tx_data_reg     <= '1;
            tx_valid_reg    <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_reg       <= frame_next;
            idx_reg         <= idx_next;
            last_idx_reg    <= last_idx_next;
            rsp_need_reg    <= rsp_need_next;
            rsp_cnt_reg     <= rsp_cnt_next;
            rsp_b_reg       <= rsp_b_next;
            timer_reg       <= timer_next;
            tx_pending_reg  <= tx_pending_next;
            busy_seen_reg   <= busy_seen_next;
            cmd_ready_reg   <= cmd_ready_next;
            tx_data_reg     <= tx_data_next;
            tx_valid_reg    <= tx_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        frame_next       = frame_reg;
        idx_next         = idx_reg;
        last_idx_next    = last_idx_reg;
        rsp_need_next    = rsp_need_reg;
        rsp_cnt_next     = rsp_cnt_reg;
        rsp_b_next       = rsp_b_reg;
        timer_next       = timer_reg;
        tx_pending_next  = tx_pending_reg;
        busy_seen_next   = busy_seen_reg;
        cmd_ready_next   = 1'b0;
        tx_data_next     = '1;
        tx_valid_next    = 1'b0;
        rsp_data_next    = rsp_data_reg;
        rsp_valid_next   = 1'b0;
        rsp_timeout_next = 1'b0;

        // A byte is only known to be taken once TX has gone busy and come back idle.
        if (tx_pending_reg) begin
            if (TX_Busy) begin
                busy_seen_next = 1'b1;
            end else if (busy_seen_reg) begin
                tx_pending_next = 1'b0;
                busy_seen_next  = 1'b0;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                cmd_ready_next = 1'b1;
                if (CMD_Valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    state_next     = ST_SEND;
                    idx_next       = '0;
                    frame_next     = '{default: '0};
                    case (CMD_Type)
                        2'b00: begin
                            frame_next[0] = DATA_WIDTH'(8'hAA);
                            frame_next[1] = DATA_WIDTH'(CMD_Addr);
                            frame_next[2] = DATA_WIDTH'(CMD_Data);
                            last_idx_next = 2'd2;
                            rsp_need_next = 2'd0;
                        end
                        2'b01: begin
                            frame_next[0] = DATA_WIDTH'(8'hBB);
                            frame_next[1] = DATA_WIDTH'(CMD_Addr);
                            last_idx_next = 2'd1;
                            rsp_need_next = 2'd1;
                        end
                        2'b10: begin
                            frame_next[0] = DATA_WIDTH'(8'hCC);
                            frame_next[1] = DATA_WIDTH'(CMD_OpA);
                            frame_next[2] = DATA_WIDTH'(CMD_OpB);
                            frame_next[3] = DATA_WIDTH'(CMD_Func);
                            last_idx_next = 2'd3;
                            rsp_need_next = 2'd2;
                        end
                        default: begin
                            frame_next[0] = DATA_WIDTH'(8'hDD);
                            frame_next[1] = DATA_WIDTH'(CMD_Func);
                            last_idx_next = 2'd1;
                            rsp_need_next = 2'd2;
                        end
                    endcase
                end
            end

            ST_SEND: begin
                if (!TX_Busy && !tx_pending_reg) begin
                    tx_valid_next   = 1'b1;
                    tx_data_next    = frame_reg[idx_reg];
                    tx_pending_next = 1'b1;
                    busy_seen_next  = 1'b0;
                    if (idx_reg == last_idx_reg) begin
                        if (rsp_need_reg == 2'd0) begin
                            state_next     = ST_DONE;
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = '0;
                        end else begin
                            state_next   = ST_RSP;
                            timer_next   = TW'(TIMEOUT);
                            rsp_cnt_next = '0;
                            rsp_b_next   = '{default: '0};
                        end
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end

            ST_RSP: begin
                // A byte in the final counter cycle takes priority over the timeout.
                if (RX_Data_Valid) begin
                    rsp_b_next[rsp_cnt_reg[0]] = RX_P_Data;
                    rsp_cnt_next = rsp_cnt_reg + 2'd1;
                    timer_next   = TW'(TIMEOUT);
                    if (rsp_cnt_reg + 2'd1 == rsp_need_reg) begin
                        state_next     = ST_DONE;
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = {rsp_b_next[1], rsp_b_next[0]};
                    end
                end else if (timer_reg <= TW'(1)) begin
                    state_next       = ST_DONE;
                    rsp_valid_next   = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_data_next    = {rsp_b_reg[1], rsp_b_reg[0]};
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end

            ST_DONE: begin
                state_next     = ST_IDLE;
                cmd_ready_next = 1'b1;
            end

            default: begin
                state_next      = ST_IDLE;
                tx_pending_next = 1'b0;
                busy_seen_next  = 1'b0;
                rsp_data_next   = '0;
            end
        endcase
    end

    assign CMD_Ready     = cmd_ready_reg;
    assign TX_P_Data     = tx_data_reg;
    assign TX_Data_Valid = tx_valid_reg;
    assign RSP_Data      = rsp_data_reg;
    assign RSP_Valid     = rsp_valid_reg;
    assign RSP_Timeout   = rsp_timeout_reg;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Bench for sys_cmd_master: UART TX/RX stand-ins, a frame/response reference model,
// a vector table, hand sequences for timing corners, and randomized commands.
`timescale 1ns/1ps
module tb_sys_cmd_master;
    localparam int T = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_Valid = 1'b0;
    logic        CMD_Ready;
    logic [1:0]  CMD_Type = '0;
    logic [3:0]  CMD_Addr = '0;
    logic [7:0]  CMD_Data = '0;
    logic [7:0]  CMD_OpA = '0;
    logic [7:0]  CMD_OpB = '0;
    logic [3:0]  CMD_Func = '0;
    logic [7:0]  TX_P_Data;
    logic        TX_Data_Valid;
    logic        TX_Busy = 1'b0;
    logic [7:0]  RX_P_Data = '0;
    logic        RX_Data_Valid = 1'b0;
    logic [15:0] RSP_Data;
    logic        RSP_Valid;
    logic        RSP_Timeout;

    always #5 CLK = ~CLK;

    sys_cmd_master #(.DATA_WIDTH(8), .TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_Valid(CMD_Valid), .CMD_Ready(CMD_Ready), .CMD_Type(CMD_Type),
        .CMD_Addr(CMD_Addr), .CMD_Data(CMD_Data), .CMD_OpA(CMD_OpA),
        .CMD_OpB(CMD_OpB), .CMD_Func(CMD_Func),
        .TX_P_Data(TX_P_Data), .TX_Data_Valid(TX_Data_Valid), .TX_Busy(TX_Busy),
        .RX_P_Data(RX_P_Data), .RX_Data_Valid(RX_Data_Valid),
        .RSP_Data(RSP_Data), .RSP_Valid(RSP_Valid), .RSP_Timeout(RSP_Timeout)
    );

    int total = 0;
    int bad = 0;

    // UART TX stand-in: records bytes, goes busy 0-1 cycles after a strobe,
    // and flags any byte strobed before the previous one finished.
    logic [7:0] tx_q[$];
    int  tx_overlap = 0;
    int  tx_phase = 0;
    int  tx_cnt = 0;
    bit  hold_busy = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (TX_Data_Valid) begin
                tx_q.push_back(TX_P_Data);
                if (tx_phase != 0) tx_overlap++;
                if ($urandom_range(0, 1) == 0) begin
                    TX_Busy = 1'b1;
                    tx_phase = 2;
                    tx_cnt = int'($urandom_range(1, 4));
                end else begin
                    tx_phase = 1;
                end
            end else if (tx_phase == 1) begin
                TX_Busy = 1'b1;
                tx_phase = 2;
                tx_cnt = int'($urandom_range(1, 4));
            end else if (tx_phase == 2) begin
                if (tx_cnt > 0) tx_cnt--;
                if (tx_cnt == 0 && !hold_busy) begin
                    TX_Busy = 1'b0;
                    tx_phase = 0;
                end
            end
        end
    end

    int          rsp_seen = 0;
    logic [15:0] rsp_last = '0;
    logic        rsp_to_last = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RSP_Valid) begin
                rsp_seen++;
                rsp_last = RSP_Data;
                rsp_to_last = RSP_Timeout;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pack_tx();
        logic [31:0] pk = '0;
        foreach (tx_q[i]) if (i < 4) pk |= 32'(tx_q[i]) << (8 * i);
        return pk;
    endfunction

    // Reference model: protocol frame as a byte list, plus expected response bytes.
    function automatic int model_frame(input logic [1:0] t, input logic [3:0] addr,
                                       input logic [7:0] d, input logic [7:0] a,
                                       input logic [7:0] b, input logic [3:0] f,
                                       output logic [31:0] pk, output int need);
        logic [7:0] q[$];
        case (t)
            2'd0: begin q = '{8'hAA, {4'h0, addr}, d}; need = 0; end
            2'd1: begin q = '{8'hBB, {4'h0, addr}}; need = 1; end
            2'd2: begin q = '{8'hCC, a, b, {4'h0, f}}; need = 2; end
            default: begin q = '{8'hDD, {4'h0, f}}; need = 2; end
        endcase
        pk = '0;
        foreach (q[i]) pk |= 32'(q[i]) << (8 * i);
        return q.size();
    endfunction

    function automatic logic [16:0] model_rsp(input int need, input int nrx,
                                              input logic [7:0] rx0, input logic [7:0] rx1);
        int got = (nrx < need) ? nrx : need;
        logic [15:0] r = '0;
        if (got >= 1) r[7:0] = rx0;
        if (got >= 2) r[15:8] = rx1;
        return {(got < need), r};
    endfunction

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] d,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        int cyc = 0;
        while (!CMD_Ready && cyc < 200) begin tick(); cyc++; end
        if (!CMD_Ready) check("cmd_ready_wait", {31'd0, CMD_Ready}, 32'd1);
        CMD_Type = t; CMD_Addr = addr; CMD_Data = d;
        CMD_OpA = a; CMD_OpB = b; CMD_Func = f;
        CMD_Valid = 1'b1;
        tick();
        CMD_Valid = 1'b0;
    endtask

    task automatic wait_frame(input int len);
        int cyc = 0;
        while (tx_q.size() < len && cyc < 1000) begin tick(); cyc++; end
    endtask

    task automatic wait_rsp();
        int cyc = 0;
        while (rsp_seen == 0 && cyc < 3 * T + 100) begin tick(); cyc++; end
    endtask

    task automatic drive_rx(input logic [7:0] v);
        RX_P_Data = v;
        RX_Data_Valid = 1'b1;
        tick();
        RX_Data_Valid = 1'b0;
        RX_P_Data = 8'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] t, input logic [3:0] addr,
                           input logic [7:0] d, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f, input int nrx, input logic [7:0] rx0,
                           input logic [7:0] rx1, input logic [31:0] exp_frame,
                           input int exp_len, input logic [15:0] exp_rsp, input logic exp_to);
        int ov0 = tx_overlap;
        tx_q.delete();
        rsp_seen = 0;
        send_cmd(t, addr, d, a, b, f);
        wait_frame(exp_len);
        for (int i = 0; i < nrx; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            drive_rx(i == 0 ? rx0 : rx1);
        end
        wait_rsp();
        repeat (3) tick();
        check({tag, " frame_len"}, tx_q.size(), exp_len);
        check({tag, " frame_bytes"}, pack_tx(), exp_frame);
        check({tag, " rsp_count"}, rsp_seen, 1);
        check({tag, " rsp_data"}, {16'd0, rsp_last}, {16'd0, exp_rsp});
        check({tag, " rsp_timeout"}, {31'd0, rsp_to_last}, {31'd0, exp_to});
        check({tag, " tx_order"}, tx_overlap - ov0, 0);
        $display("txn %s: type=%0d frame=%h len=%0d rsp=%h timeout=%0b", tag, t, pack_tx(),
                 tx_q.size(), rsp_last, rsp_to_last);
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [3:0]  addr;
        logic [7:0]  d, a, b;
        logic [3:0]  f;
        int          nrx;
        logic [7:0]  rx0, rx1;
        logic [31:0] frm;
        int          len;
        logic [15:0] rsp;
        logic        to;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] pk;
        int need, len, cnt;
        logic [16:0] er;
        logic [1:0] rt;
        logic [3:0] raddr, rf;
        logic [7:0] rd, ra, rb, r0, r1;
        int rnrx;

        vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 32'h003C05AA, 3, 16'h0000, 1'b0};
        vecs[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h7E, 8'h00, 32'h000002BB, 2, 16'h007E, 1'b0};
        vecs[2] = '{2'd2, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0, 2, 8'hC8, 8'h00, 32'h00140ACC, 4, 16'h00C8, 1'b0};
        vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 1, 8'h34, 8'h00, 32'h000002DD, 2, 16'h0034, 1'b1};
        vecs[4] = '{2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 32'h00000FBB, 2, 16'h0000, 1'b1};
        vecs[5] = '{2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 2, 8'h00, 8'hFF, 32'h0F01FFCC, 4, 16'hFF00, 1'b0};
        vecs[6] = '{2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 2, 8'h12, 8'h34, 32'h000000DD, 2, 16'h3412, 1'b0};

        // Reset values, then CMD_Ready one cycle after release.
        repeat (3) tick();
        check("rst_cmd_ready", {31'd0, CMD_Ready}, 32'd0);
        check("rst_tx_data", {24'd0, TX_P_Data}, 32'h0000_00FF);
        check("rst_tx_valid", {31'd0, TX_Data_Valid}, 32'd0);
        check("rst_rsp", {13'd0, RSP_Timeout, RSP_Valid, 1'b0, RSP_Data}, 32'd0);
        RST = 1'b1;
        tick();
        check("ready_after_release", {31'd0, CMD_Ready}, 32'd1);

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].addr, vecs[i].d, vecs[i].a,
                    vecs[i].b, vecs[i].f, vecs[i].nrx, vecs[i].rx0, vecs[i].rx1,
                    vecs[i].frm, vecs[i].len, vecs[i].rsp, vecs[i].to);
        end

        // Timeout exactly TIMEOUT idle cycles after the last received byte.
        tx_q.delete(); rsp_seen = 0;
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
        wait_frame(2);
        drive_rx(8'h34);
        cnt = 0;
        while (rsp_seen == 0 && cnt < T + 20) begin tick(); cnt++; end
        check("timeout_latency", cnt, T);
        check("timeout_data", {15'd0, rsp_to_last, rsp_last}, {15'd0, 1'b1, 16'h0034});
        $display("txn timeout_seq: latency=%0d rsp=%h timeout=%0b", cnt, rsp_last, rsp_to_last);
        repeat (3) tick();

        // Byte landing in the last counter cycle completes the response.
        tx_q.delete(); rsp_seen = 0;
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5);
        wait_frame(2);
        drive_rx(8'h11);
        repeat (T - 1) tick();
        drive_rx(8'h22);
        wait_rsp();
        check("byte_wins", {15'd0, rsp_to_last, rsp_last}, {15'd0, 1'b0, 16'h2211});
        $display("txn byte_wins_seq: rsp=%h timeout=%0b", rsp_last, rsp_to_last);
        repeat (3) tick();

        // TX busy held 100 cycles mid-frame; spurious RX byte during SEND.
        tx_q.delete(); rsp_seen = 0;
        hold_busy = 1'b1;
        send_cmd(2'd2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
        wait_frame(1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) drive_rx(8'hEE);
            else tick();
        end
        check("stall_no_tx", tx_q.size(), 1);
        hold_busy = 1'b0;
        wait_frame(4);
        drive_rx(8'h55);
        drive_rx(8'h66);
        wait_rsp();
        repeat (3) tick();
        check("stall_frame", pack_tx(), 32'h032211CC);
        check("stall_rsp", {15'd0, rsp_to_last, rsp_last}, {15'd0, 1'b0, 16'h6655});
        $display("txn stall_seq: frame=%h rsp=%h timeout=%0b", pack_tx(), rsp_last, rsp_to_last);

        // Reset while the third ALU_OP byte is on the TX port.
        tx_q.delete(); rsp_seen = 0;
        send_cmd(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'h4);
        wait_frame(3);
        RST = 1'b0;
        #1;
        check("midrst_tx", {23'd0, TX_Data_Valid, TX_P_Data}, 32'h0000_00FF);
        check("midrst_ctl", {29'd0, CMD_Ready, RSP_Valid, RSP_Timeout}, 32'd0);
        check("midrst_rsp_data", {16'd0, RSP_Data}, 32'd0);
        repeat (2) tick();
        RST = 1'b1;
        repeat (20) tick();
        check("midrst_no_rsp", rsp_seen, 0);
        check("midrst_no_more_tx", tx_q.size(), 3);
        $display("txn reset_seq: bytes_before_reset=%0d rsp_pulses=%0d", tx_q.size(), rsp_seen);
        run_txn("after_reset", 2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'hA5, 8'h00,
                32'h000009BB, 2, 16'h00A5, 1'b0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 25; n++) begin
            rt = 2'($urandom); raddr = 4'($urandom); rd = 8'($urandom);
            ra = 8'($urandom); rb = 8'($urandom); rf = 4'($urandom);
            r0 = 8'($urandom); r1 = 8'($urandom);
            len = model_frame(rt, raddr, rd, ra, rb, rf, pk, need);
            rnrx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, need)) : need;
            er = model_rsp(need, rnrx, r0, r1);
            run_txn($sformatf("rand%0d", n), rt, raddr, rd, ra, rb, rf, rnrx, r0, r1,
                    pk, len, er[15:0], er[16]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
